quad_encoder_emitter: RTL and testbench
=======================================

Name: quad_encoder_emitter

Overview:
- Rotary-encoder emulator: the transmit side of the ROT_A/ROT_B/btn quadrature interface consumed by the encoder decoder.
- Accepts step and press commands over a valid/ready handshake and produces detent-accurate Gray-code quadrature and button waveforms.
- Used for bench self-test and for driving the encoder path from on-chip logic; runs on the divided display clock (clk_out).

Parameters:
- PHASE_CYCLES, 1000: clk cycles each quadrature phase is held; must be >= 1.
- PRESS_CYCLES, 5000: clk cycles btn is held high per press; must be >= 1.
- GAP_CYCLES, 5000: clk cycles btn is held low after release before the next command; must be >= 1.
- CNT_W, 4: width of the step repeat count.
- POS_W, 5: width of the emitted-position counter, matching the 5-bit encoder result.

Ports:
- clk  in  1  block clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  emitter can accept a command.
- cmd_op  in  2  00 = CW step, 01 = CCW step, 10 = button press, 11 = reserved (no-op).
- cmd_count  in  CNT_W  number of steps for op 00/01; ignored for 10/11.
- ROT_A  out  1  quadrature channel A, idle high.
- ROT_B  out  1  quadrature channel B, idle high.
- btn  out  1  push-button, active high.
- done  out  1  one-cycle pulse when a command completes.
- pos  out  POS_W  net emitted steps, two's complement, wraps.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, ROT_A=1, ROT_B=1, btn=0, done=0, pos=0, cmd_ready=1, all counters 0.
- Reset mid-operation aborts the command immediately; the partial step is not counted in pos; the A/B glitch this causes is accepted.
- All outputs are registered except cmd_ready, which is combinational: cmd_ready = (state == IDLE).
- Accept occurs on a rising edge with cmd_valid && cmd_ready; cmd_op and cmd_count are latched on that edge.
- cmd_valid and input changes outside IDLE are ignored.
- FSM states: IDLE, STEP, PRESS, GAP.
- IDLE, on accept:
  - op 00/01 with count > 0 -> STEP. First phase value is driven on the accept edge; remaining-step counter = count.
  - op 00/01 with count = 0, or op 11 -> stay IDLE; done=1 on the cycle after accept; no pin activity.
  - op 10 -> PRESS; btn=1 driven on the accept edge.
- STEP phase sequence, with detent at (A,B)=11:
  - CW: 01, 00, 10, 11.
  - CCW: 10, 00, 01, 11.
- Each phase is held exactly PHASE_CYCLES cycles; one step = 4*PHASE_CYCLES cycles.
- On expiry of the 4th phase (11), on the same edge:
  - pos += 1 for CW, pos -= 1 for CCW, modulo 2^POS_W;
  - remaining decrements;
  - if remaining becomes 0 -> IDLE with done=1 for one cycle; otherwise the next step's first phase is driven, with no extra idle cycle.
- Total STEP duration is count*4*PHASE_CYCLES cycles from accept edge to IDLE entry.
- Only one of A/B changes per phase transition; A and B never change on the same edge.
- PRESS: btn=1 for PRESS_CYCLES cycles, then btn=0 and -> GAP.
- GAP: GAP_CYCLES cycles with btn=0, then -> IDLE with done=1. pos is unchanged by press commands.
- Back-to-back commands: with cmd_valid held, the next command is accepted on the first edge where state is IDLE, which is the same cycle done is high.
- Minimum spacing between consecutive steps equals normal phase timing; the detent 11 is always held a full PHASE_CYCLES.
- pos wraps: 2^POS_W-1 + CW -> 0; 0 + CCW -> 2^POS_W-1.
- ROT_A/ROT_B hold 11 and btn holds 0 in IDLE.

Test Plan:
- Reset: all tests use PHASE_CYCLES=2, PRESS_CYCLES=3, GAP_CYCLES=2. Hold reset_n=0, then release -> ROT_A=1, ROT_B=1, btn=0, pos=0, done=0, cmd_ready=1.
- Single CW step: op=00, count=1 -> (A,B) = 01,01,00,00,10,10,11,11 over 8 cycles; done pulses at IDLE entry; pos=1; cmd_ready low for exactly 8 cycles.
- Multi CCW step: from pos=1, op=01, count=3 -> three repetitions of 10,00,01,11 at 2 cycles each (24 cycles), single done at end, pos=5'h1E. Checker confirms only one of A/B toggles per edge.
- Zero count / reserved op: op=00 count=0, then op=11 -> each gives done one cycle after accept; A/B/btn never leave idle; pos unchanged.
- Press and back-to-back: op=10 followed immediately by op=00 count=1 with cmd_valid held -> btn high 3 cycles, low 2 cycles, done, CW step accepted that same cycle; pos +1.
- Wrap and reset abort:
  - Preload pos=31 via 31 CW steps, then 1 CW step -> pos=0.
  - Start op=00 count=2, assert reset_n=0 mid-phase 00 -> A/B=11, btn=0, pos=0 immediately, cmd_ready=1.

Source files
------------

// File: rtl/quad_encoder_emitter.sv
// Rotary-encoder emulator: turns step/press commands into Gray-code ROT_A/ROT_B
// quadrature and btn waveforms with detent-accurate phase timing.
module quad_encoder_emitter #(
    parameter int PHASE_CYCLES = 1000,
    parameter int PRESS_CYCLES = 5000,
    parameter int GAP_CYCLES   = 5000,
    parameter int CNT_W        = 4,
    parameter int POS_W        = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ROT_A,
    output logic             ROT_B,
    output logic             btn,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    localparam int TMR_MAX_PS = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
    localparam int TMR_MAX    = (TMR_MAX_PS > GAP_CYCLES) ? TMR_MAX_PS : GAP_CYCLES;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] T_PHASE = TMR_W'(PHASE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_PRESS = TMR_W'(PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STEP, PRESS, GAP} state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [1:0]         phase, phase_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic               dir, dir_nxt;
    logic [1:0]         ab, ab_nxt;
    logic               btn_nxt;
    logic               done_nxt;
    logic [POS_W-1:0]   pos_nxt;

    // dir=0 is CW (01,00,10,11), dir=1 is CCW (10,00,01,11); detent is 11.
    function automatic logic [1:0] phase_ab(input logic d, input logic [1:0] idx);
        case (idx)
            2'd0:    phase_ab = d ? 2'b10 : 2'b01;
            2'd1:    phase_ab = 2'b00;
            2'd2:    phase_ab = d ? 2'b01 : 2'b10;
            default: phase_ab = 2'b11;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign ROT_A     = ab[1];
    assign ROT_B     = ab[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            phase     <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            ab        <= 2'b11;
            btn       <= 1'b0;
            done      <= 1'b0;
            pos       <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            phase     <= phase_nxt;
            remaining <= remaining_nxt;
            dir       <= dir_nxt;
            ab        <= ab_nxt;
            btn       <= btn_nxt;
            done      <= done_nxt;
            pos       <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        phase_nxt     = phase;
        remaining_nxt = remaining;
        dir_nxt       = dir;
        ab_nxt        = ab;
        btn_nxt       = btn;
        done_nxt      = 1'b0;
        pos_nxt       = pos;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00, 2'b01: begin
                            if (cmd_count != '0) begin
                                state_nxt     = STEP;
                                dir_nxt       = cmd_op[0];
                                phase_nxt     = 2'd0;
                                ab_nxt        = phase_ab(cmd_op[0], 2'd0);
                                timer_nxt     = T_PHASE;
                                remaining_nxt = cmd_count;
                            end else begin
                                done_nxt = 1'b1;
                            end
                        end
                        2'b10: begin
                            state_nxt = PRESS;
                            btn_nxt   = 1'b1;
                            timer_nxt = T_PRESS;
                        end
                        default: done_nxt = 1'b1;
                    endcase
                end
            end
            STEP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (phase != 2'd3) begin
                    phase_nxt = phase + 2'd1;
                    ab_nxt    = phase_ab(dir, phase + 2'd1);
                    timer_nxt = T_PHASE;
                end else begin
                    // Detent expired: the step is complete and counted here.
                    pos_nxt       = dir ? pos - 1'b1 : pos + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    phase_nxt     = 2'd0;
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        ab_nxt    = phase_ab(dir, 2'd0);
                        timer_nxt = T_PHASE;
                    end
                end
            end
            PRESS: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
                    state_nxt = GAP;
                    btn_nxt   = 1'b0;
                    timer_nxt = T_GAP;
                end
            end
            GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_quad_encoder_emitter.sv
// Directed bench for quad_encoder_emitter with PHASE=2, PRESS=3, GAP=2;
// expected waveforms are hand-computed tables.
module tb_quad_encoder_emitter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic       ROT_A, ROT_B, btn, done;
    logic [4:0] pos;

    int checks = 0;
    int errors = 0;

    logic [1:0] cw_seq  [4];
    logic [1:0] ccw_seq [4];
    logic [1:0] prev_ab;

    quad_encoder_emitter #(
        .PHASE_CYCLES(2), .PRESS_CYCLES(3), .GAP_CYCLES(2), .CNT_W(4), .POS_W(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .ROT_A(ROT_A), .ROT_B(ROT_B),
        .btn(btn), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while idle; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] cnt);
        cmd_op = op; cmd_count = cnt; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk); n++;
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        cw_seq[0] = 2'b01; cw_seq[1] = 2'b00; cw_seq[2] = 2'b10; cw_seq[3] = 2'b11;
        ccw_seq[0] = 2'b10; ccw_seq[1] = 2'b00; ccw_seq[2] = 2'b01; ccw_seq[3] = 2'b11;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        check_eq("rst_btn", {31'd0, btn}, 32'd0);
        check_eq("rst_pos", {27'd0, pos}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Single CW step
        issue(2'b00, 4'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("cw_ab", {30'd0, ROT_A, ROT_B}, {30'd0, cw_seq[i/2]});
            check_eq("cw_ready_low", {31'd0, cmd_ready}, 32'd0);
        end
        @(negedge clk);
        check_eq("cw_done", {31'd0, done}, 32'd1);
        check_eq("cw_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("cw_pos", {27'd0, pos}, 32'd1);

        // Three CCW steps from pos=1
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        prev_ab = 2'b11;
        issue(2'b01, 4'd3);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check_eq("ccw_ab", {30'd0, ROT_A, ROT_B}, {30'd0, ccw_seq[(i/2)%4]});
            check_eq("ccw_one_toggle", {31'd0, ((prev_ab ^ {ROT_A, ROT_B}) != 2'b11)}, 32'd1);
            check_eq("ccw_no_done", {31'd0, done}, 32'd0);
            prev_ab = {ROT_A, ROT_B};
        end
        @(negedge clk);
        check_eq("ccw_done", {31'd0, done}, 32'd1);
        check_eq("ccw_pos", {27'd0, pos}, 32'h1E);
        @(negedge clk);
        check_eq("ccw_done_once", {31'd0, done}, 32'd0);

        // Zero count, then reserved op
        issue(2'b00, 4'd0);
        @(negedge clk);
        check_eq("zero_done", {31'd0, done}, 32'd1);
        check_eq("zero_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        check_eq("zero_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check_eq("zero_done_clr", {31'd0, done}, 32'd0);
        issue(2'b11, 4'd5);
        @(negedge clk);
        check_eq("rsv_done", {31'd0, done}, 32'd1);
        check_eq("rsv_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        check_eq("rsv_btn", {31'd0, btn}, 32'd0);
        check_eq("rsv_pos", {27'd0, pos}, 32'h1E);
        @(negedge clk);

        // Press followed by back-to-back CW step with cmd_valid held
        cmd_op = 2'b10; cmd_count = 4'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 2'b00; cmd_count = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("press_btn", {31'd0, btn}, (i < 3) ? 32'd1 : 32'd0);
            check_eq("press_ready_low", {31'd0, cmd_ready}, 32'd0);
            check_eq("press_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        end
        @(negedge clk);
        check_eq("press_done", {31'd0, done}, 32'd1);
        check_eq("press_pos", {27'd0, pos}, 32'h1E);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_first_phase", {30'd0, ROT_A, ROT_B}, 32'h1);
        wait_done(20);
        check_eq("b2b_pos", {27'd0, pos}, 32'h1F);
        @(negedge clk);

        // Fresh reset, preload pos=31 with 31 CW steps, then wrap
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 4'd15); wait_done(200);
        issue(2'b00, 4'd15); wait_done(200);
        issue(2'b00, 4'd1);  wait_done(20);
        check_eq("preload_pos", {27'd0, pos}, 32'd31);
        issue(2'b00, 4'd1);  wait_done(20);
        check_eq("wrap_up_pos", {27'd0, pos}, 32'd0);
        issue(2'b01, 4'd1);  wait_done(20);
        check_eq("wrap_down_pos", {27'd0, pos}, 32'd31);
        issue(2'b00, 4'd1);  wait_done(20);
        check_eq("wrap_back_pos", {27'd0, pos}, 32'd0);

        // Reset abort in the middle of phase 00
        issue(2'b00, 4'd2);
        repeat (3) @(negedge clk);
        check_eq("abort_mid_ab", {30'd0, ROT_A, ROT_B}, 32'h0);
        reset_n = 1'b0;
        #1;
        check_eq("abort_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        check_eq("abort_btn", {31'd0, btn}, 32'd0);
        check_eq("abort_pos", {27'd0, pos}, 32'd0);
        check_eq("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_abort_ab", {30'd0, ROT_A, ROT_B}, 32'h3);
        check_eq("post_abort_pos", {27'd0, pos}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
